// File: rtl/vanilla_remote_req_responder.sv
// Serves one remote load/store/atomic request at a time against the tile's 1RW data memory
// and returns a single response carrying the register id and the loaded or pre-AMO word.
module vanilla_remote_req_responder #(
   parameter int data_width_p   = 32,
   parameter int dmem_els_p     = 1024,
   parameter int reg_id_width_p = 5,
   localparam int dmem_addr_width_lp = $clog2(dmem_els_p),
   localparam int mask_width_lp      = data_width_p / 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,

   input  logic                          v_i,
   input  logic                          write_not_read_i,
   input  logic                          is_amo_op_i,
   input  logic [1:0]                    amo_type_i,
   input  logic [mask_width_lp-1:0]      mask_i,
   input  logic [reg_id_width_p-1:0]     reg_id_i,
   input  logic [data_width_p-1:0]       data_i,
   input  logic [31:0]                   addr_i,
   output logic                          yumi_o,

   output logic                          dmem_v_o,
   output logic                          dmem_w_o,
   output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
   output logic [data_width_p-1:0]       dmem_data_o,
   output logic [mask_width_lp-1:0]      dmem_mask_o,
   input  logic [data_width_p-1:0]       dmem_data_i,

   output logic                          resp_v_o,
   input  logic                          resp_ready_i,
   output logic [reg_id_width_p-1:0]     resp_reg_id_o,
   output logic                          resp_is_write_o,
   output logic [data_width_p-1:0]       resp_data_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      AMO_WR = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      AMO_SWAP = 2'd0,
      AMO_OR   = 2'd1,
      AMO_ADD  = 2'd2,
      AMO_RSVD = 2'd3
   } amo_e;

   state_e                          state_q, state_d;
   logic [reg_id_width_p-1:0]       reg_id_q, reg_id_d;
   logic                            is_write_q, is_write_d;
   logic                            is_amo_q, is_amo_d;
   amo_e                            amo_type_q, amo_type_d;
   logic [data_width_p-1:0]         operand_q, operand_d;
   logic [dmem_addr_width_lp-1:0]   addr_q, addr_d;
   logic [data_width_p-1:0]         resp_data_q, resp_data_d;

   logic [dmem_addr_width_lp-1:0]   req_index;
   logic                            req_is_store;
   logic [data_width_p-1:0]         amo_result;
   logic                            unused_addr_bits;

   // Only the word index is meaningful; byte offset and bits above the memory are dropped,
   // so addresses past the end of the memory wrap.
   assign req_index        = addr_i[2 +: dmem_addr_width_lp];
   assign unused_addr_bits = ^{addr_i[31:2+dmem_addr_width_lp], addr_i[1:0]};
   assign req_is_store     = write_not_read_i & ~is_amo_op_i;

   always_comb begin
      amo_result = operand_q;
      case (amo_type_q)
         AMO_SWAP: amo_result = operand_q;
         AMO_OR:   amo_result = resp_data_q | operand_q;
         AMO_ADD:  amo_result = resp_data_q + operand_q;
         default:  amo_result = resp_data_q;
      endcase
   end

   // Request side: v_i/yumi_o, where yumi_o is a same-cycle consume that only follows v_i in IDLE.
   // Response side: resp_v_o/resp_ready_i, fields held stable until the cycle both are high.
   always_comb begin
      state_d     = state_q;
      reg_id_d    = reg_id_q;
      is_write_d  = is_write_q;
      is_amo_d    = is_amo_q;
      amo_type_d  = amo_type_q;
      operand_d   = operand_q;
      addr_d      = addr_q;
      resp_data_d = resp_data_q;

      yumi_o      = 1'b0;
      dmem_v_o    = 1'b0;
      dmem_w_o    = 1'b0;
      dmem_addr_o = addr_q;
      dmem_data_o = operand_q;
      dmem_mask_o = '0;
      resp_v_o    = 1'b0;

      case (state_q)
         IDLE: begin
            if (v_i) begin
               yumi_o      = 1'b1;
               dmem_v_o    = 1'b1;
               dmem_addr_o = req_index;
               dmem_data_o = data_i;
               reg_id_d    = reg_id_i;
               is_write_d  = req_is_store;
               is_amo_d    = is_amo_op_i;
               amo_type_d  = amo_e'(amo_type_i);
               operand_d   = data_i;
               addr_d      = req_index;
               if (req_is_store) begin
                  dmem_w_o    = 1'b1;
                  dmem_mask_o = mask_i;
                  resp_data_d = '0;
                  state_d     = RESP;
               end else begin
                  state_d     = READ;
               end
            end
         end

         READ: begin
            resp_data_d = dmem_data_i;
            state_d     = is_amo_q ? AMO_WR : RESP;
         end

         AMO_WR: begin
            // resp_data_q already holds the old word, which is what the response returns.
            if (amo_type_q != AMO_RSVD) begin
               dmem_v_o    = 1'b1;
               dmem_w_o    = 1'b1;
               dmem_mask_o = '1;
               dmem_data_o = amo_result;
            end
            state_d = RESP;
         end

         RESP: begin
            resp_v_o = 1'b1;
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (reset_i) begin
         yumi_o   = 1'b0;
         dmem_v_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         reg_id_q    <= '0;
         is_write_q  <= 1'b0;
         is_amo_q    <= 1'b0;
         amo_type_q  <= AMO_SWAP;
         operand_q   <= '0;
         addr_q      <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         reg_id_q    <= reg_id_d;
         is_write_q  <= is_write_d;
         is_amo_q    <= is_amo_d;
         amo_type_q  <= amo_type_d;
         operand_q   <= operand_d;
         addr_q      <= addr_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign resp_reg_id_o   = reg_id_q;
   assign resp_is_write_o = is_write_q;
   assign resp_data_o     = resp_data_q;

endmodule

// File: doc/vanilla_remote_req_responder.md
# vanilla_remote_req_responder

Tile-side responder for vanilla-core remote requests. It accepts one remote request at a time (load, store, or atomic swap/or/add) from the network endpoint and executes it against the tile's local 1RW data memory. Atomics are done as a read-modify-write. It then returns a single response carrying the register id and the load or old data. It is the serving end of the core's remote request / remote load response path.

## Interface
Parameters:
- data_width_p, 32, word width.
- dmem_els_p, 1024, data memory words; dmem_addr_width_lp = log2(dmem_els_p).
- reg_id_width_p, 5, register id width (matches manycore reg_id width).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. One clock; reset is synchronous and active-high.
- v_i  in  1  request valid.
- write_not_read_i  in  1  store (1) / load (0); ignored when is_amo_op_i=1.
- is_amo_op_i  in  1  atomic request.
- amo_type_i  in  2  0=swap, 1=or, 2=add, 3=reserved.
- mask_i  in  4  byte mask, stores only.
- reg_id_i  in  reg_id_width_p  destination register id.
- data_i  in  32  store or AMO operand.
- addr_i  in  32  byte address; word index = addr_i[2+:dmem_addr_width_lp], other bits ignored.
- yumi_o  out  1  request consumed this cycle.
- dmem_v_o  out  1  memory access this cycle.
- dmem_w_o  out  1  write (1) / read (0).
- dmem_addr_o  out  dmem_addr_width_lp  word index.
- dmem_data_o  out  32  write data.
- dmem_mask_o  out  4  byte write mask.
- dmem_data_i  in  32  read data, valid the cycle after a read.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response accepted when resp_v_o & resp_ready_i.
- resp_reg_id_o  out  reg_id_width_p  register id.
- resp_is_write_o  out  1  response is a store acknowledge.
- resp_data_o  out  32  loaded word, or the old value for an AMO; 0 for stores.

## Operation
- FSM states: IDLE, READ, AMO_WR, RESP.
- **IDLE:**
  - yumi_o = v_i, combinational. dmem_v_o = v_i.
  - On v_i, latch reg_id, operation, data and word index.
  - Store: dmem write with mask_i and data_i, then go to RESP with resp_data=0 and resp_is_write=1.
  - Load or AMO: dmem read, then go to READ.
- **READ:** dmem_v_o=0. Capture dmem_data_i into resp_data. Load goes to RESP. AMO goes to AMO_WR.
- **AMO_WR:**
  - Write new = swap: data; or: old|data; add: (old+data) mod 2^32.
  - Write uses mask 4'b1111 at the latched index; mask_i is ignored for AMO.
  - Reserved amo_type: no write (dmem_v_o=0).
  - Always go to RESP; the response carries the old value.
- **RESP:** resp_v_o=1, with all response fields held stable until resp_ready_i. On handshake, go to IDLE. No new request is accepted in the handshake cycle.
- Loads always read and return the full word; part-select is the requester's job.
- Only one request is in flight, so there are no address hazards.

## Timing
- Reset values: state=IDLE; resp_v_o=0, resp_data_o=0, resp_reg_id_o=0, resp_is_write_o=0; yumi_o=0 and dmem_v_o=0 while reset_i=1.
- Reset during READ/AMO_WR/RESP aborts the request: a pending AMO write is not issued and the response is dropped.
- Request accepted at cycle T:
  - Store: dmem write at T; resp_v_o from T+1.
  - Load: read at T, capture at T+1; resp_v_o from T+2.
  - AMO: read at T, capture at T+1, write at T+2; resp_v_o from T+3.
- Next acceptance is no earlier than the cycle after the response handshake.
  - Peak throughput with resp_ready_i tied high: store 1 per 2 cycles, load 1 per 3, AMO 1 per 4.
- Backpressure: with resp_ready_i low, the FSM stays in RESP indefinitely, yumi_o=0 and dmem_v_o=0.
- Address wrap: addr_i=0x1000 with dmem_els_p=1024 maps to index 0.

## Test plan
- Store then load: store data=0xDEADBEEF, mask=4'b0011, index 5 over prior 0x11223344. Store response: resp_is_write=1, data=0. Load with reg_id=7 returns 0x1122BEEF, reg_id=7, resp_v_o at T+2.
- AMO add: mem[3]=0xFFFFFFFF, operand 2. Response is 0xFFFFFFFF; mem[3] becomes 0x00000001. AMO or: 0x0F0 | 0xF00 leaves 0xFF0 in memory and returns 0x0F0. AMO swap returns old and stores the operand.
- Reserved amo_type=3 on mem[9]=0xABCD: response 0xABCD, no dmem write, mem unchanged.
- Backpressure: resp_ready_i=0 for 10 cycles with v_i held high. yumi_o stays 0, dmem idle and the response is stable. On release the handshake completes, and the next request is accepted the following cycle.
- Reset mid-AMO: assert reset_i in AMO_WR. No write occurs, resp_v_o=0, and after reset a load sees the original value.
- Address wrap: a store to addr 0x1004 is read back by a load of addr 0x0004 (index 1).
